// File: rtl/dmem_pkg.sv
// dmem_pkg: shared access-size encodings and sweep FSM states for dmem_bank.
package dmem_pkg;

   // Access size as presented on the size port
   typedef enum logic [1:0] {
      SZ_B   = 2'd0,
      SZ_H   = 2'd1,
      SZ_W   = 2'd2,
      SZ_RSV = 2'd3
   } size_e;

   // INIT runs the zero-fill sweep, READY serves loads and stores
   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

endpackage : dmem_pkg

// File: rtl/dmem_load_align.sv
// dmem_load_align: picks the addressed byte/half lane out of a 32-bit word
// and sign- or zero-extends it to 32 bits.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   input  size_e       size_i,
   input  logic        uns_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   // Lane select followed by extension; reserved size yields zero
   always_comb begin
      byte_c = 8'h00;
      half_c = 16'h0000;
      data_o = 32'h0000_0000;

      case (lane_i)
         2'd0:    byte_c = word_i[7:0];
         2'd1:    byte_c = word_i[15:8];
         2'd2:    byte_c = word_i[23:16];
         default: byte_c = word_i[31:24];
      endcase

      half_c = lane_i[1] ? word_i[31:16] : word_i[15:0];

      case (size_i)
         SZ_B:    data_o = {{24{byte_c[7] & ~uns_i}}, byte_c};
         SZ_H:    data_o = {{16{half_c[15] & ~uns_i}}, half_c};
         SZ_W:    data_o = word_i;
         default: data_o = 32'h0000_0000;
      endcase
   end

endmodule : dmem_load_align

// File: rtl/dmem_bank.sv
// dmem_bank: byte-addressable data memory with byte/half/word access,
// misalignment flagging and a post-reset zero-fill sweep.
// Optional feature: define DMEM_RDREG_EN to register rdata (1-cycle load).
module dmem_bank
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 4096,
   parameter int unsigned AW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   input  logic          we,
   input  logic [1:0]    size,
   input  logic          uns,
   output logic [31:0]   rdata,
   output logic          err,
   output logic          busy
);

   localparam int unsigned IW    = $clog2(DEPTH);
   localparam int unsigned LANES = 4;

   state_e            state_q, state_d;
   logic [IW-1:0]     cnt_q, cnt_d;
   logic [31:0]       mem_q [DEPTH];

   size_e             sz_c;
   logic [IW-1:0]     idx_c;
   logic [LANES-1:0]  be_c;
   logic [31:0]       wdat_c;

   logic              wr_en_c;
   logic [IW-1:0]     wr_idx_c;
   logic [LANES-1:0]  wr_be_c;
   logic [31:0]       wr_data_c;

   logic [31:0]       rd_word_c;
   logic [31:0]       ld_c;
   logic [31:0]       rd_c;

   assign sz_c  = size_e'(size);
   assign idx_c = addr[IW+1:2];

   // Address bits above the array are ignored so accesses wrap
   if (AW > IW + 2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[AW-1:IW+2];
   end

   // Misaligned or reserved-size access detection
   assign err = (sz_c == SZ_RSV)
              | ((sz_c == SZ_H) & addr[0])
              | ((sz_c == SZ_W) & (addr[1:0] != 2'b00));

   assign busy = (state_q == INIT);

   // Sweep FSM state and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Sweep FSM next state: walk every word once, then stay in READY
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         INIT: begin
            cnt_d = cnt_q + IW'(1);
            if (cnt_q == IW'(DEPTH - 1)) begin
               state_d = READY;
            end
         end
         READY:   state_d = READY;
         default: state_d = INIT;
      endcase
   end

   // Byte enables and lane-replicated store data for the addressed lanes
   always_comb begin
      be_c   = '0;
      wdat_c = wdata;
      case (sz_c)
         SZ_B: begin
            be_c   = 4'b0001 << addr[1:0];
            wdat_c = {4{wdata[7:0]}};
         end
         SZ_H: begin
            be_c   = addr[1] ? 4'b1100 : 4'b0011;
            wdat_c = {2{wdata[15:0]}};
         end
         SZ_W: begin
            be_c   = 4'b1111;
            wdat_c = wdata;
         end
         default: be_c = '0;
      endcase
   end

   // Single write port: sweep owns it in INIT, legal stores in READY
   always_comb begin
      wr_en_c   = 1'b0;
      wr_idx_c  = idx_c;
      wr_be_c   = '0;
      wr_data_c = 32'h0000_0000;
      if (busy) begin
         wr_en_c   = 1'b1;
         wr_idx_c  = cnt_q;
         wr_be_c   = 4'b1111;
      end else if (we && !err) begin
         wr_en_c   = 1'b1;
         wr_be_c   = be_c;
         wr_data_c = wdat_c;
      end
   end

   // Storage array, byte-lane writes; no reset, the sweep clears it
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         for (int b = 0; b < int'(LANES); b++) begin
            if (wr_be_c[b]) begin
               mem_q[wr_idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
            end
         end
      end
   end

   assign rd_word_c = mem_q[idx_c];

   dmem_load_align u_align (
      .word_i (rd_word_c),
      .lane_i (addr[1:0]),
      .size_i (sz_c),
      .uns_i  (uns),
      .data_o (ld_c)
   );

   assign rd_c = (err || busy) ? 32'h0000_0000 : ld_c;

`ifdef DMEM_RDREG_EN
   logic [31:0] rdata_q;

   // Registered load path; array read precedes the write so it is read-first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= 32'h0000_0000;
      end else begin
         rdata_q <= rd_c;
      end
   end

   assign rdata = rdata_q;
`else
   assign rdata = rd_c;
`endif

endmodule : dmem_bank

// File: tb/tb_dmem_bank.sv
// tb_dmem_bank: table-driven check of dmem_bank (DEPTH = 16) with a
// latency-aware scoreboard for load data.
module tb_dmem_bank;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 32;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic          we;
   logic [1:0]    size;
   logic          uns;
   logic [31:0]   rdata;
   logic          err;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;

   vec_t vq[$];
   sb_t  sbq[$];

   dmem_bank #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (addr),
      .wdata (wdata),
      .we    (we),
      .size  (size),
      .uns   (uns),
      .rdata (rdata),
      .err   (err),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [1:0] sz,
                               input logic u, input logic [31:0] wd, input logic e,
                               input logic [31:0] rd);
      vec_t v;
      v.we = w; v.addr = a; v.size = sz; v.uns = u; v.wdata = wd;
      v.exp_err = e; v.exp_rd = rd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle();
      we = 1'b0; addr = '0; size = 2'd2; uns = 1'b0; wdata = '0;
   endtask

   task automatic pop_check();
      sb_t s;
      if (sbq.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         s = sbq.pop_front();
         check(s.name, rdata, s.exp);
      end
   endtask

   // One vector per cycle; err is checked combinationally, rdata via scoreboard
   task automatic run_vecs(input string tag);
      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         we = vq[i].we; addr = vq[i].addr; size = vq[i].size;
         uns = vq[i].uns; wdata = vq[i].wdata;
         sbq.push_back('{$sformatf("%s[%0d].rdata", tag, i), vq[i].exp_rd});
         #1;
         check($sformatf("%s[%0d].err", tag, i), 32'(err), 32'(vq[i].exp_err));
`ifdef DMEM_RDREG_EN
         @(posedge clk);
         #1;
`endif
         pop_check();
      end
      @(negedge clk);
      idle();
      vq.delete();
   endtask

   // Count rising edges until busy drops; bounded
   task automatic count_busy(input string tag);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 64) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) check({tag, ".rdata_while_busy"}, rdata, 32'h0);
      end
      we = 1'b0;
      check({tag, ".busy_cycles"}, 32'(n), 32'(DEPTH));
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      size  = 2'd3;
      repeat (3) @(negedge clk);
      check("reset.busy", 32'(busy), 32'd1);
      check("reset.rdata", rdata, 32'h0);
      check("reset.err_rsv", 32'(err), 32'd1);

      // Store attempted for the whole sweep must be dropped
      we = 1'b1; addr = 32'h4; size = 2'd2; wdata = 32'hDEADBEEF;
      rst_n = 1'b1;
      count_busy("sweep1");
      @(negedge clk);
      idle();
      check("ready.busy", 32'(busy), 32'd0);

      // B=0 H=1 W=2 R=3
      vq.push_back(mk(0, 32'h00, 2, 0, 0,            0, 32'h00000000));
      vq.push_back(mk(0, 32'h3C, 2, 0, 0,            0, 32'h00000000));
      vq.push_back(mk(1, 32'h08, 2, 0, 32'h11223344, 0, 32'h00000000));
      vq.push_back(mk(1, 32'h09, 0, 0, 32'h000000AA, 0, 32'h00000033));
      vq.push_back(mk(0, 32'h08, 2, 0, 0,            0, 32'h1122AA44));
      vq.push_back(mk(0, 32'h09, 0, 0, 0,            0, 32'hFFFFFFAA));
      vq.push_back(mk(0, 32'h09, 0, 1, 0,            0, 32'h000000AA));
      vq.push_back(mk(0, 32'h0A, 1, 0, 0,            0, 32'h00001122));
      vq.push_back(mk(1, 32'h03, 1, 0, 32'h0000FFFF, 1, 32'h00000000));
      vq.push_back(mk(1, 32'h06, 2, 0, 32'hFFFFFFFF, 1, 32'h00000000));
      vq.push_back(mk(0, 32'h00, 2, 0, 0,            0, 32'h00000000));
      vq.push_back(mk(0, 32'h04, 2, 0, 0,            0, 32'h00000000));
      vq.push_back(mk(1, 32'h08, 3, 0, 32'h55555555, 1, 32'h00000000));
      vq.push_back(mk(0, 32'h08, 2, 0, 0,            0, 32'h1122AA44));
      vq.push_back(mk(0, 32'h08, 1, 1, 0,            0, 32'h0000AA44));
      vq.push_back(mk(0, 32'h08, 1, 0, 0,            0, 32'hFFFFAA44));
      vq.push_back(mk(1, 32'h40, 2, 0, 32'hCAFEF00D, 0, 32'h00000000));
      vq.push_back(mk(0, 32'h00, 2, 0, 0,            0, 32'hCAFEF00D));
      vq.push_back(mk(1, 32'h02, 1, 1, 32'h00008001, 0, 32'h0000CAFE));
      vq.push_back(mk(0, 32'h00, 2, 0, 0,            0, 32'h8001F00D));
      vq.push_back(mk(0, 32'h02, 1, 0, 0,            0, 32'hFFFF8001));
      vq.push_back(mk(0, 32'h03, 0, 0, 0,            0, 32'hFFFFFF80));
      vq.push_back(mk(0, 32'h3C, 2, 0, 0,            0, 32'h00000000));
      run_vecs("tbl");

      // Same-word store and load in back-to-back cycles: read-first
      vq.push_back(mk(1, 32'h30, 2, 0, 32'hA5A5A5A5, 0, 32'h00000000));
      vq.push_back(mk(1, 32'h30, 2, 0, 32'h12345678, 0, 32'hA5A5A5A5));
      vq.push_back(mk(0, 32'h30, 2, 0, 0,            0, 32'h12345678));
      run_vecs("rfw");

      // Reset pulse at sweep count 7 restarts the full sweep
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset.busy", 32'(busy), 32'd1);
      #1;
      rst_n = 1'b1;
      count_busy("sweep2");
      @(negedge clk);
      idle();
      for (int w = 0; w < int'(DEPTH); w++) begin
         vq.push_back(mk(0, 32'(4 * w), 2, 0, 0, 0, 32'h00000000));
      end
      run_vecs("zero");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_dmem_bank

// File: doc/dmem_bank.md
# dmem_bank

Parametrised byte-addressable data memory for the single-cycle core, replacing the flat word-only data store. Supports byte, halfword and word loads and stores with lane selection and sign or zero extension, and flags misaligned or reserved-size accesses. After reset it runs a hardware zero-fill sweep, so no large asynchronously reset array is needed. Sits between the ALU address path and the writeback mux.

## Interface
- DEPTH, 4096: number of 32-bit words; power of two, ≥ 4.
- AW, 32: byte-address width; must be ≥ log2(DEPTH)+2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- addr  in  AW  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- we  in  1  store strobe.
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- uns  in  1  load zero-extends when 1, sign-extends when 0.
- rdata  out  32  load data, aligned and extended.
- err  out  1  misaligned or reserved-size access; combinational.
- busy  out  1  init sweep in progress.

## Operation
- Word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
- err = 1 when any of these hold:
  - size = 3;
  - size = 1 and addr[0] = 1;
  - size = 2 and addr[1:0] ≠ 0.
- FSM states:
  - INIT: entered on reset with sweep counter = 0. Each cycle writes 0 to word[cnt], then cnt increments. At cnt = DEPTH-1 the FSM moves to READY on the next edge.
  - READY: normal operation; terminal until the next reset.
- busy = 1 exactly while in INIT.
- Store, in READY with we = 1 and err = 0:
  - byte: writes wdata[7:0] into lane addr[1:0].
  - half: writes wdata[15:0] into lanes addr[1] × 2 and addr[1] × 2 + 1.
  - word: writes all four lanes.
  - Other lanes are unchanged.
- Store is suppressed when err = 1 or busy = 1. Memory is unchanged in both cases.
- Load: selects the addressed lane or lanes, then extends to 32 bits per uns. For word loads uns is ignored.
- rdata = 0 when err = 1 or busy = 1.
- Read during write to the same word in the same cycle returns the old contents. The new value is visible from the next cycle.

## Timing
- Reset values: busy = 1, FSM = INIT, cnt = 0, rdata = 0 (when registered). err follows its inputs combinationally.
- busy stays high for exactly DEPTH rising edges after rst_n deasserts, then falls.
- rst_n asserted mid-sweep or in READY: FSM returns to INIT and cnt returns to 0 immediately; the sweep restarts from word 0.
- Default read latency is 0: rdata is combinational from addr, size, uns and array contents.
- Store latency is 1: the write commits on the edge where we is sampled.

## Configuration
- DMEM_RDREG_EN defined: rdata is registered. Load data for the address presented in cycle N appears in cycle N+1.
  - Read-first: a store and load to the same word in cycle N returns the old data in N+1.
  - The register resets to 0 and loads 0 when err or busy was set in cycle N.
  - err remains combinational.
- DMEM_RDREG_EN undefined: 0-cycle combinational read as described in Operation.

## Structure
- Shared package dmem_pkg:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_RSV;
  - FSM state typedef (INIT, READY).
- One sub-module, dmem_load_align: combinational lane select and sign or zero extension from the 32-bit word, addr[1:0], size and uns.
- Byte-enable generation and the sweep counter stay in the top module.

## Test plan
All scenarios use DEPTH = 16.
- Reset release: busy high for exactly 16 cycles, then low. Word loads at 0x0 and 0x3C return 0x00000000.
- Word store 0x11223344 at 0x8, then byte store 0xAA at 0x9:
  - word load at 0x8 returns 0x1122AA44;
  - byte load at 0x9 with uns = 0 returns 0xFFFFFFAA;
  - byte load at 0x9 with uns = 1 returns 0x000000AA;
  - half load at 0xA with uns = 0 returns 0x00001122.
- Half store at 0x3 and word store at 0x6: err = 1 and memory is unchanged. size = 3 gives err = 1 and rdata = 0.
- Store of 0xDEADBEEF at 0x4 while busy is ignored: after the sweep, the word at 0x4 is 0.
- Wrap: word store 0xCAFEF00D at 0x40, then word load at 0x0 returns 0xCAFEF00D.
- rst_n pulsed mid-sweep at cnt = 7: busy stays high for 16 full cycles after release, and all words read 0.
- With DMEM_RDREG_EN defined: load at 0x8 appears one cycle later. A store and load to the same word in the same cycle returns the old value.
